// File: rtl/regfile_8x_onehot.sv
// rtl/regfile_8x_onehot.sv - eight-entry register file with one-hot write select, bypassed read ports and select-error logging
module regfile_8x_onehot #(
    parameter int WIDTH    = 16,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       we_onehot,
    input  logic [WIDTH-1:0] wdata,
    input  logic [2:0]       ra_addr,
    input  logic [2:0]       rb_addr,
    input  logic             rd_en,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic             rd_valid,
    input  logic             clear_err,
    output logic             onehot_err,
    output logic [7:0]       err_count
);

    logic [WIDTH-1:0] regs [8];
    logic [3:0]       pop;
    logic             wr_ok;
    logic             wr_bad;
    logic [WIDTH-1:0] ra_next;
    logic [WIDTH-1:0] rb_next;

    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'd0, we_onehot[i]};
        end
    end

    assign wr_ok  = (pop == 4'd1);
    assign wr_bad = (pop > 4'd1);

    // Bypass only on a well-formed write; the zero register masks everything, bypass included.
    always_comb begin
        ra_next = regs[ra_addr];
        rb_next = regs[rb_addr];
        if (wr_ok && we_onehot[ra_addr]) begin
            ra_next = wdata;
        end
        if (wr_ok && we_onehot[rb_addr]) begin
            rb_next = wdata;
        end
        if (ZERO_REG && (ra_addr == 3'd0)) begin
            ra_next = '0;
        end
        if (ZERO_REG && (rb_addr == 3'd0)) begin
            rb_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_ok && we_onehot[i] && !(ZERO_REG && (i == 0))) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ra_data  <= '0;
            rb_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                ra_data <= ra_next;
                rb_data <= rb_next;
            end
        end
    end

    // A fresh error outranks a simultaneous clear so the event is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            onehot_err <= 1'b0;
            err_count  <= 8'd0;
        end else if (wr_bad) begin
            onehot_err <= 1'b1;
            if (clear_err) begin
                err_count <= 8'd1;
            end else if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end else if (clear_err) begin
            onehot_err <= 1'b0;
            err_count  <= 8'd0;
        end
    end

endmodule

// File: tb/tb_regfile_8x_onehot.sv
// tb/tb_regfile_8x_onehot.sv - self-checking bench for regfile_8x_onehot with ZERO_REG=1 and ZERO_REG=0 instances
module tb_regfile_8x_onehot;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  we_onehot;
    logic [15:0] wdata;
    logic [2:0]  ra_addr;
    logic [2:0]  rb_addr;
    logic        rd_en;
    logic        clear_err;

    logic [15:0] ra_z, rb_z, ra_n, rb_n;
    logic        v_z, v_n, err_z, err_n;
    logic [7:0]  cnt_z, cnt_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_8x_onehot #(.WIDTH(16), .ZERO_REG(1'b1)) u_z (
        .clk(clk), .reset(reset), .we_onehot(we_onehot), .wdata(wdata),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_en(rd_en),
        .ra_data(ra_z), .rb_data(rb_z), .rd_valid(v_z),
        .clear_err(clear_err), .onehot_err(err_z), .err_count(cnt_z)
    );

    regfile_8x_onehot #(.WIDTH(16), .ZERO_REG(1'b0)) u_n (
        .clk(clk), .reset(reset), .we_onehot(we_onehot), .wdata(wdata),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_en(rd_en),
        .ra_data(ra_n), .rb_data(rb_n), .rd_valid(v_n),
        .clear_err(clear_err), .onehot_err(err_n), .err_count(cnt_n)
    );

    // Reference model: index 0 models ZERO_REG=1, index 1 models ZERO_REG=0.
    logic [15:0] m_mem [2][8];
    logic [15:0] m_ra  [2];
    logic [15:0] m_rb  [2];
    logic        m_v   [2];
    logic        m_err [2];
    int          m_cnt [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input int k, input logic [2:0] a);
        int pop;
        pop = $countones(we_onehot);
        if (k == 0 && a == 3'd0) return 16'h0;
        if (pop == 1 && we_onehot == (8'h01 << a)) return wdata;
        return m_mem[k][a];
    endfunction

    task automatic model_update();
        int pop;
        pop = $countones(we_onehot);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 8; i++) m_mem[k][i] = 16'h0;
                m_ra[k] = 16'h0; m_rb[k] = 16'h0; m_v[k] = 1'b0;
                m_err[k] = 1'b0; m_cnt[k] = 0;
            end else begin
                m_v[k] = rd_en;
                if (rd_en) begin
                    m_ra[k] = model_read(k, ra_addr);
                    m_rb[k] = model_read(k, rb_addr);
                end
                if (pop == 1) begin
                    for (int i = 0; i < 8; i++)
                        if (we_onehot == (8'h01 << i) && !(k == 0 && i == 0)) m_mem[k][i] = wdata;
                end
                if (pop >= 2) begin
                    m_err[k] = 1'b1;
                    m_cnt[k] = clear_err ? 1 : ((m_cnt[k] < 255) ? m_cnt[k] + 1 : 255);
                end else if (clear_err) begin
                    m_err[k] = 1'b0;
                    m_cnt[k] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] w, input logic [15:0] d,
                        input logic [2:0] a, input logic [2:0] b, input logic re, input logic c);
        reset = r; we_onehot = w; wdata = d; ra_addr = a; rb_addr = b; rd_en = re; clear_err = c;
        @(posedge clk);
        #1;
        model_update();
        chk("model_ra_z",  {16'h0, ra_z},  {16'h0, m_ra[0]});
        chk("model_rb_z",  {16'h0, rb_z},  {16'h0, m_rb[0]});
        chk("model_v_z",   {31'h0, v_z},   {31'h0, m_v[0]});
        chk("model_err_z", {31'h0, err_z}, {31'h0, m_err[0]});
        chk("model_cnt_z", {24'h0, cnt_z}, m_cnt[0]);
        chk("model_ra_n",  {16'h0, ra_n},  {16'h0, m_ra[1]});
        chk("model_rb_n",  {16'h0, rb_n},  {16'h0, m_rb[1]});
        chk("model_v_n",   {31'h0, v_n},   {31'h0, m_v[1]});
        chk("model_err_n", {31'h0, err_n}, {31'h0, m_err[1]});
        chk("model_cnt_n", {24'h0, cnt_n}, m_cnt[1]);
    endtask

    typedef struct {
        logic        rst;
        logic [7:0]  we;
        logic [15:0] wd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        rd;
        logic        clr;
        logic [15:0] exp_ra;
        logic [15:0] exp_ra_n;
        logic [15:0] exp_rb;
        logic        exp_v;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [7:0] w;
        //            rst we     wd        ra rb rd clr  exp_ra    exp_ra_n  exp_rb    v  err cnt
        tbl[0]  = '{1, 8'h00, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 8'd0};
        tbl[1]  = '{0, 8'h08, 16'hA5A5, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 8'd0};
        tbl[2]  = '{0, 8'h00, 16'h0000, 3, 3, 1, 0, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1, 0, 8'd0};
        tbl[3]  = '{0, 8'h00, 16'h0000, 0, 0, 0, 0, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0, 0, 8'd0};
        tbl[4]  = '{0, 8'h10, 16'h0007, 0, 0, 0, 0, 16'hA5A5, 16'hA5A5, 16'hA5A5, 0, 0, 8'd0};
        tbl[5]  = '{0, 8'h20, 16'h1234, 5, 4, 1, 0, 16'h1234, 16'h1234, 16'h0007, 1, 0, 8'd0};
        tbl[6]  = '{0, 8'h01, 16'hFFFF, 0, 0, 0, 0, 16'h1234, 16'h1234, 16'h0007, 0, 0, 8'd0};
        tbl[7]  = '{0, 8'h00, 16'h0000, 0, 5, 1, 0, 16'h0000, 16'hFFFF, 16'h1234, 1, 0, 8'd0};
        tbl[8]  = '{0, 8'h02, 16'h0011, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h1234, 0, 0, 8'd0};
        tbl[9]  = '{0, 8'h04, 16'h0022, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h1234, 0, 0, 8'd0};
        tbl[10] = '{0, 8'h06, 16'hDEAD, 1, 2, 1, 0, 16'h0011, 16'h0011, 16'h0022, 1, 1, 8'd1};
        tbl[11] = '{0, 8'h00, 16'h0000, 1, 2, 1, 0, 16'h0011, 16'h0011, 16'h0022, 1, 1, 8'd1};
        tbl[12] = '{0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0011, 16'h0011, 16'h0022, 0, 0, 8'd0};
        tbl[13] = '{0, 8'hFF, 16'h0000, 0, 0, 0, 1, 16'h0011, 16'h0011, 16'h0022, 0, 1, 8'd1};
        tbl[14] = '{0, 8'h00, 16'h0000, 0, 0, 0, 1, 16'h0011, 16'h0011, 16'h0022, 0, 0, 8'd0};
        tbl[15] = '{0, 8'h80, 16'h00FF, 0, 0, 0, 0, 16'h0011, 16'h0011, 16'h0022, 0, 0, 8'd0};
        tbl[16] = '{1, 8'h40, 16'h0BAD, 6, 7, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 8'd0};
        tbl[17] = '{0, 8'h00, 16'h0000, 6, 7, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 8'd0};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].we, tbl[i].wd, tbl[i].ra, tbl[i].rb, tbl[i].rd, tbl[i].clr);
            chk($sformatf("vec%0d_ra_z", i),   {16'h0, ra_z},  {16'h0, tbl[i].exp_ra});
            chk($sformatf("vec%0d_ra_n", i),   {16'h0, ra_n},  {16'h0, tbl[i].exp_ra_n});
            chk($sformatf("vec%0d_rb_z", i),   {16'h0, rb_z},  {16'h0, tbl[i].exp_rb});
            chk($sformatf("vec%0d_valid", i),  {31'h0, v_z},   {31'h0, tbl[i].exp_v});
            chk($sformatf("vec%0d_err", i),    {31'h0, err_z}, {31'h0, tbl[i].exp_err});
            chk($sformatf("vec%0d_cnt", i),    {24'h0, cnt_z}, {24'h0, tbl[i].exp_cnt});
        end

        // Saturation: 300 malformed selects after preloading two registers.
        step(0, 8'h02, 16'h0011, 0, 0, 0, 0);
        step(0, 8'h04, 16'h0022, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            w = 8'($urandom);
            while ($countones(w) < 2) w = 8'($urandom);
            step(0, w, 16'($urandom), 3'($urandom), 3'($urandom), 1'b0, 1'b0);
        end
        chk("sat_cnt", {24'h0, cnt_z}, 32'd255);
        chk("sat_err", {31'h0, err_z}, 32'd1);
        step(0, 8'h00, 16'h0000, 1, 2, 1, 0);
        chk("sat_reg1", {16'h0, ra_z}, 32'h0011);
        chk("sat_reg2", {16'h0, rb_z}, 32'h0022);
        step(0, 8'h00, 16'h0000, 0, 0, 0, 1);
        chk("clear_cnt", {24'h0, cnt_z}, 32'd0);
        chk("clear_err", {31'h0, err_z}, 32'd0);
        step(0, 8'hFF, 16'h0000, 0, 0, 0, 1);
        chk("clear_vs_err_cnt", {24'h0, cnt_z}, 32'd1);
        chk("clear_vs_err_flag", {31'h0, err_z}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 2))
                0:       w = 8'h00;
                1:       w = 8'h01 << $urandom_range(0, 7);
                default: w = 8'($urandom);
            endcase
            step(($urandom_range(0, 99) == 0), w, 16'($urandom), 3'($urandom), 3'($urandom),
                 1'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_8x_onehot.md
Name: regfile_8x_onehot

Overview:
- Eight-entry general-purpose register file for the processor model.
- Sits directly downstream of the 3-to-8 write-address decoder and consumes its one-hot write-select vector.
- Provides two registered read ports with write-to-read bypass.
- Polices the one-hot contract: malformed select vectors are rejected and logged with a sticky error flag and a saturating counter.

Parameters:
- WIDTH, 16, data width of each register and of the write/read data buses.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero; 0 = register 0 is an ordinary register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- we_onehot  input  8  one-hot write select from the write-address decoder; bit i selects register i.
- wdata  input  WIDTH  write data.
- ra_addr  input  3  read port A address.
- rb_addr  input  3  read port B address.
- rd_en  input  1  read request; samples both addresses.
- ra_data  output  WIDTH  read port A data, registered.
- rb_data  output  WIDTH  read port B data, registered.
- rd_valid  output  1  high for one cycle when ra_data/rb_data carry the result of a read request.
- clear_err  input  1  clears onehot_err and err_count.
- onehot_err  output  1  sticky flag: a malformed we_onehot was seen.
- err_count  output  8  number of malformed we_onehot cycles, saturating at 255.

Behaviour:
- One clock domain. Reset is synchronous and active-high; clock port is clk, reset port is reset.
- Reset has priority over all other inputs, including a write, read or error on the same edge.
- Reset values: all 8 registers 0, ra_data 0, rb_data 0, rd_valid 0, onehot_err 0, err_count 0.
- Write classification of we_onehot each cycle:
  - popcount 0: idle, no write.
  - popcount 1: valid write; register i <= wdata at the edge.
  - popcount >= 2: malformed; no register is written, and an error event occurs.
- When ZERO_REG=1:
  - we_onehot = 8'h01 is a valid, discarded write and is not an error.
  - Register 0 always reads 0, including via bypass.
- Error event:
  - onehot_err <= 1.
  - err_count <= err_count + 1, saturating at 255; it holds at 255 on further errors.
- clear_err without an error event in the same cycle: onehot_err <= 0, err_count <= 0.
- clear_err and an error event in the same cycle: the new error wins; onehot_err <= 1, err_count <= 1.
- Read latency is 1 cycle. When rd_en=1 at edge N:
  - At N+1, ra_data = contents of reg[ra_addr], rb_data = contents of reg[rb_addr], rd_valid = 1.
- Bypass: if a valid write at edge N targets ra_addr (or rb_addr), that port returns the new wdata, not the stale value.
  - A malformed write never bypasses.
  - Both ports may read the same address; both get identical data.
- rd_en=0: ra_data and rb_data hold their previous values; rd_valid <= 0.
- Back-to-back reads on consecutive cycles return a result every cycle (full throughput).
- Write and read in the same cycle to different addresses are independent.
- Register contents persist indefinitely; only writes and reset change them.

Test Plan:
- Reset, then write 16'hA5A5 with we_onehot=8'h08, then next cycle rd_en=1, ra_addr=3, rb_addr=3 -> one cycle later ra_data=rb_data=16'hA5A5, rd_valid=1; the following cycle with rd_en=0 gives rd_valid=0 with data held.
- Same-cycle write 16'h1234 via we_onehot=8'h20 and rd_en=1, ra_addr=5, rb_addr=4, where reg4 holds 16'h0007 -> next cycle ra_data=16'h1234 (bypass), rb_data=16'h0007.
- ZERO_REG=1: write 16'hFFFF with we_onehot=8'h01, then read ra_addr=0 -> ra_data=0, onehot_err=0; repeat with ZERO_REG=0 -> ra_data=16'hFFFF.
- Preload reg1=16'h0011, reg2=16'h0022; apply we_onehot=8'h06 with wdata=16'hDEAD -> reg1=16'h0011 and reg2=16'h0022 unchanged, onehot_err=1, err_count=1; drive 300 malformed cycles -> err_count=255.
- clear_err alone -> onehot_err=0, err_count=0; clear_err together with we_onehot=8'hFF -> onehot_err=1, err_count=1.
- Write reg7=16'h00FF, then assert reset on the same edge as a write of 16'h0BAD to reg6 and rd_en=1 -> after reset all reads return 0, rd_valid=0, onehot_err=0.
